fir_edge_pad: RTL and testbench
===============================

// Module: fir_edge_pad
// PURPOSE
//  Upstream stage of the 2-D FIR: horizontal border replication on the raw pixel stream.
//  Per line, emits the first pixel REPEAT_NUM extra times before the line and the last
//  pixel REPEAT_NUM extra times after it, so the 3-tap h-filter sees valid edge context.
//  Tracks pixel/line position and tags output with sol/eol/sof/eof. valid/ready both sides.
// PARAMETERS
//  DATA_WIDTH  8   pixel width
//  LINE_CNT    12  width of size/position counters
//  REPEAT_NUM  2   replicated pixels per edge; legal range 1..7
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           synchronous reset, active-low
//  h_size_i   in   LINE_CNT    last pixel index of a line (width-1); sampled at frame start
//  v_size_i   in   LINE_CNT    last line index of a frame (height-1); sampled at frame start
//  s_valid_i  in   1           input pixel valid
//  s_ready_o  out  1           input pixel accepted when s_valid_i & s_ready_o
//  s_data_i   in   DATA_WIDTH  input pixel
//  m_valid_o  out  1           output word valid (registered)
//  m_ready_i  in   1           downstream accepts word when m_valid_o & m_ready_i
//  m_data_o   out  DATA_WIDTH  padded pixel (registered)
//  m_sol_o    out  1           first word of an output line
//  m_eol_o    out  1           last word of an output line
//  m_sof_o    out  1           first word of a frame (line 0, sol)
//  m_eof_o    out  1           last word of a frame (line v_size, eol)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): m_valid_o, m_data_o, m_sol/eol/sof/eof_o = 0; FSM=IDLE;
//    pixel/line/pad counters = 0; s_ready_o = 0 while rst_n=0. Mid-line reset discards line.
//  - slot_free = !m_valid_o | m_ready_i. Output regs load only when slot_free; otherwise
//    m_data_o and all flags hold stable (no change while m_valid_o & !m_ready_i).
//  - Output line = W+2R words, W=h_size+1, R=REPEAT_NUM: p0 x(R+1), p1..p(W-2), p(W-1) x(R+1).
//  - FSM:
//    IDLE: s_ready_o=slot_free. On accept: edge_r<=p0, emit p0 with sol (sof if line 0),
//          pad_cnt<=R-1, pix_cnt<=1 -> LPAD. At line 0 sample h_size_i/v_size_i into regs.
//    LPAD: s_ready_o=0. Each slot_free cycle emit edge_r; at pad_cnt==0 emit ->
//          BODY if W>1, else pad_cnt<=R-1 -> RPAD (W=1 line = 2R+1 copies of p0).
//    BODY: s_ready_o=slot_free. Each accept emits pixel; pix_cnt++. On accept with
//          pix_cnt==h_size: edge_r<=pixel, pad_cnt<=R-1 -> RPAD.
//    RPAD: s_ready_o=0. Each slot_free cycle emit edge_r; word with pad_cnt==0 carries
//          eol (eof if line==v_size) -> IDLE; line_cnt++ or wraps to 0 after v_size.
//  - Latency: accepted pixel appears on m_data_o the next cycle. Throughput 1 word/cycle
//    with m_ready_i=1; input stalls exactly 2R cycles per line.
//  - h_size_i/v_size_i changes mid-frame ignored until next frame start (IDLE, line 0).
//  - Counters compare with ==; no overflow beyond LINE_CNT. Pixel data never modified.
//  - s_valid_i low in BODY: no output, FSM holds; padding proceeds without s_valid_i.
// STRUCTURE
//  - fir_defs.vh (shared): FSM state localparams IDLE/LPAD/BODY/RPAD, pad counter width
//    (clog2 of REPEAT_NUM max), flag bit ordering of {sof,sol,eol,eof} sideband.
//  - One sub-module: fir_pix_oreg — registered output slot (data+4 flags), load when
//    slot_free & emit, exports slot_free. FSM/counters live in fir_edge_pad.
// TESTING
//  1 R=2,h_size=3,v_size=0; in 10,20,30,40, m_ready=1 -> out 10,10,10,20,30,40,40,40;
//    sol/sof on word0, eol/eof on word7; s_ready_o low 4 cycles total.
//  2 Same line, m_ready_i pattern 1,0,0,1,0,1... -> identical sequence, m_data_o stable
//    during every stall, no drop/dup; s_valid_i gaps in BODY -> identical output.
//  3 h_size=0,R=2, in 55 -> out 55 x5, word0 sol, word4 eol.
//  4 v_size=1,h_size=1,R=1: lines (1,2),(3,4) -> 1,1,2,2 | 3,3,4,4; sof only word0,
//    eof only word7; third line starts new frame with sof.
//  5 Change h_size 3->5 during line 0 -> frame uses 3; next frame uses 5 (10 words/line).
//  6 rst_n=0 one cycle during LPAD -> next cycle all outputs 0; next pixel restarts line 0
//    with sof.

Source files
------------

// File: rtl/fir_edge_pad_pkg.sv
// Shared definitions for the horizontal edge-replication stage: FSM states,
// pad counter sizing and the bit order of the {sof,sol,eol,eof} sideband.
package fir_edge_pad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LPAD = 2'd1,
    BODY = 2'd2,
    RPAD = 2'd3
  } state_e;

  // REPEAT_NUM is limited to 1..7, so the pad down-counter needs 3 bits.
  localparam int REPEAT_MAX = 7;
  localparam int PAD_W      = $clog2(REPEAT_MAX);

  // Sideband ordering, MSB first: {sof, sol, eol, eof}
  localparam int FLAG_W   = 4;
  localparam int FLAG_SOF = 3;
  localparam int FLAG_SOL = 2;
  localparam int FLAG_EOL = 1;
  localparam int FLAG_EOF = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  function automatic flags_t mk_flags(input logic sof, input logic sol,
                                      input logic eol, input logic eof);
    return {sof, sol, eol, eof};
  endfunction

endpackage

// File: rtl/fir_edge_pad_pix_oreg.sv
// Registered output slot: one word of pixel data plus frame/line sideband.
// Loads a new word whenever the slot is empty or being drained this cycle.
module fir_edge_pad_pix_oreg
  import fir_edge_pad_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  flags_t                flags_i,
  input  logic                  m_ready_i,
  output logic                  slot_free_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output flags_t                m_flags_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  flags_t                flags_q, flags_d;

  assign slot_free_o = !valid_q || m_ready_i;

  // Take a new word only when the slot can move; otherwise hold everything
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    flags_d = flags_q;
    if (slot_free_o) begin
      valid_d = load_i;
      if (load_i) begin
        data_d  = data_i;
        flags_d = flags_i;
      end
    end
  end

  // Output slot register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_flags_o = flags_q;

endmodule

// File: rtl/fir_edge_pad.sv
// Horizontal border replication ahead of the 2-D FIR: each line goes out as
// p0 x(R+1), p1..p(W-2), p(W-1) x(R+1), tagged with sol/eol/sof/eof.
module fir_edge_pad
  import fir_edge_pad_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_CNT   = 12,
  parameter int REPEAT_NUM = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LINE_CNT-1:0]   h_size_i,
  input  logic [LINE_CNT-1:0]   v_size_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_sol_o,
  output logic                  m_eol_o,
  output logic                  m_sof_o,
  output logic                  m_eof_o
);

  localparam logic [PAD_W-1:0] PAD_INIT = PAD_W'(REPEAT_NUM - 1);

  state_e                state_q,    state_d;
  logic [LINE_CNT-1:0]   pix_cnt_q,  pix_cnt_d;
  logic [LINE_CNT-1:0]   line_cnt_q, line_cnt_d;
  logic [LINE_CNT-1:0]   h_size_q,   h_size_d;
  logic [LINE_CNT-1:0]   v_size_q,   v_size_d;
  logic [PAD_W-1:0]      pad_cnt_q,  pad_cnt_d;
  logic [DATA_WIDTH-1:0] edge_px_q,  edge_px_d;

  logic                  slot_free;
  logic                  s_ready;
  logic                  emit;
  logic [DATA_WIDTH-1:0] emit_data;
  flags_t                emit_flags;
  flags_t                m_flags;

  // Line sequencing: decide what to emit this cycle and where to go next
  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    h_size_d   = h_size_q;
    v_size_d   = v_size_q;
    pad_cnt_d  = pad_cnt_q;
    edge_px_d  = edge_px_q;
    s_ready    = 1'b0;
    emit       = 1'b0;
    emit_data  = edge_px_q;
    emit_flags = '0;

    case (state_q)
      IDLE: begin
        s_ready = slot_free && rst_n;
        if (s_valid_i && s_ready) begin
          emit       = 1'b1;
          emit_data  = s_data_i;
          emit_flags = mk_flags(line_cnt_q == '0, 1'b1, 1'b0, 1'b0);
          edge_px_d  = s_data_i;
          pad_cnt_d  = PAD_INIT;
          pix_cnt_d  = LINE_CNT'(1);
          state_d    = LPAD;
          // Frame geometry is frozen for the whole frame at its first pixel
          if (line_cnt_q == '0) begin
            h_size_d = h_size_i;
            v_size_d = v_size_i;
          end
        end
      end

      LPAD: begin
        if (slot_free) begin
          emit      = 1'b1;
          pad_cnt_d = pad_cnt_q - 1'b1;
          if (pad_cnt_q == '0) begin
            if (h_size_q != '0) begin
              state_d = BODY;
            end else begin
              // Single-pixel line: right padding replicates the same pixel
              pad_cnt_d = PAD_INIT;
              state_d   = RPAD;
            end
          end
        end
      end

      BODY: begin
        s_ready = slot_free && rst_n;
        if (s_valid_i && s_ready) begin
          emit      = 1'b1;
          emit_data = s_data_i;
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (pix_cnt_q == h_size_q) begin
            edge_px_d = s_data_i;
            pad_cnt_d = PAD_INIT;
            state_d   = RPAD;
          end
        end
      end

      RPAD: begin
        if (slot_free) begin
          emit      = 1'b1;
          pad_cnt_d = pad_cnt_q - 1'b1;
          if (pad_cnt_q == '0) begin
            emit_flags = mk_flags(1'b0, 1'b0, 1'b1, line_cnt_q == v_size_q);
            state_d    = IDLE;
            line_cnt_d = (line_cnt_q == v_size_q) ? '0 : line_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state and position counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      h_size_q   <= '0;
      v_size_q   <= '0;
      pad_cnt_q  <= '0;
      edge_px_q  <= '0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      h_size_q   <= h_size_d;
      v_size_q   <= v_size_d;
      pad_cnt_q  <= pad_cnt_d;
      edge_px_q  <= edge_px_d;
    end
  end

  fir_edge_pad_pix_oreg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_oreg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (emit),
    .data_i      (emit_data),
    .flags_i     (emit_flags),
    .m_ready_i   (m_ready_i),
    .slot_free_o (slot_free),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_flags_o   (m_flags)
  );

  assign s_ready_o = s_ready;
  assign m_sof_o   = m_flags[FLAG_SOF];
  assign m_sol_o   = m_flags[FLAG_SOL];
  assign m_eol_o   = m_flags[FLAG_EOL];
  assign m_eof_o   = m_flags[FLAG_EOF];

endmodule

// File: tb/tb_fir_edge_pad.sv
// Bench for fir_edge_pad: directed edge cases plus randomized frames checked
// against a line-composition model.
module tb_fir_edge_pad;

  localparam int DW = 8;
  localparam int LC = 12;
  localparam int R  = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          sol;
    logic          eol;
    logic          eof;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LC-1:0] h_size;
  logic [LC-1:0] v_size;
  logic          s_valid;
  logic          s_ready_o;
  logic [DW-1:0] s_data;
  logic          m_valid_o;
  logic          m_ready;
  logic [DW-1:0] m_data_o;
  logic          m_sol_o, m_eol_o, m_sof_o, m_eof_o;

  always #5 clk = ~clk;

  fir_edge_pad #(
    .DATA_WIDTH (DW),
    .LINE_CNT   (LC),
    .REPEAT_NUM (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .h_size_i  (h_size),
    .v_size_i  (v_size),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready),
    .m_data_o  (m_data_o),
    .m_sol_o   (m_sol_o),
    .m_eol_o   (m_eol_o),
    .m_sof_o   (m_sof_o),
    .m_eof_o   (m_eof_o)
  );

  int            n_cmp  = 0;
  int            n_fail = 0;
  word_t         exp_q[$];
  logic [DW-1:0] src_q[$];
  int            low_rdy;

  function automatic word_t dut_word();
    return {m_data_o, m_sof_o, m_sol_o, m_eol_o, m_eof_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Model: an output line is the input line with its first and last pixel
  // each repeated R extra times; the word index selects the source pixel.
  task automatic add_frame(input int h, input int v, input int base, input int step,
                           input bit rnd);
    logic [DW-1:0] px[];
    int            w, total, idx;
    word_t         e;
    w     = h + 1;
    total = w + 2 * R;
    px    = new[w];
    for (int l = 0; l <= v; l++) begin
      for (int i = 0; i < w; i++) begin
        px[i] = rnd ? DW'($urandom) : DW'(base + step * (l * w + i));
        src_q.push_back(px[i]);
      end
      for (int k = 0; k < total; k++) begin
        if (k <= R)                 idx = 0;
        else if (k >= w + R - 1)    idx = w - 1;
        else                        idx = k - R;
        e.d   = px[idx];
        e.sol = (k == 0);
        e.eol = (k == total - 1);
        e.sof = (k == 0) && (l == 0);
        e.eof = (k == total - 1) && (l == v);
        exp_q.push_back(e);
      end
    end
  endtask

  // Runs source and sink until every queued pixel is accepted and every
  // expected word is taken. Entered and left just after a rising edge.
  // ready_mode: 0 always ready, 1 fixed 1,0,0,1,0,1 pattern, 2 random.
  task automatic run_stream(input string tag, input int max_cyc, input int ready_mode,
                            input bit gaps, input int chg_cyc, input int chg_h);
    int    cyc = 0;
    bit    hold_pend = 1'b0;
    word_t hold_w, w;
    bit    pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    low_rdy = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && cyc < max_cyc) begin
      if (cyc == chg_cyc) h_size = LC'(chg_h);
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = pat[cyc % 6];
        default: m_ready = ($urandom_range(0, 2) != 0);
      endcase
      s_valid = (src_q.size() != 0) && (!gaps || $urandom_range(0, 2) != 0);
      s_data  = (src_q.size() != 0) ? src_q[0] : DW'($urandom);
      if (!s_valid) s_data = DW'($urandom);
      @(negedge clk);
      w = dut_word();
      if (hold_pend) begin
        check({tag, "_stall_valid"}, 32'(m_valid_o), 32'd1);
        check({tag, "_stall_word"}, 32'(w), 32'(hold_w));
      end
      hold_pend = m_valid_o && !m_ready;
      hold_w    = w;
      if (!s_ready_o) low_rdy++;
      if (m_valid_o && m_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_word"}, 32'(w), 32'hFFFF_FFFF);
        end else begin
          check({tag, "_word"}, 32'(w), 32'(exp_q.pop_front()));
        end
      end
      if (s_valid && s_ready_o) void'(src_q.pop_front());
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= max_cyc) begin
      check({tag, "_timeout_left"}, 32'(exp_q.size() + src_q.size()), 32'd0);
      exp_q.delete();
      src_q.delete();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check({tag, "_no_extra"}, 32'(m_valid_o), 32'd0);
    @(posedge clk);
    #1;
  endtask

  word_t t1[8];

  initial begin
    rst_n   = 1'b0;
    h_size  = '0;
    v_size  = '0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid_o), 32'd0);
    check("rst_word", 32'(dut_word()), 32'd0);
    check("rst_s_ready", 32'(s_ready_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: one line, table of expected words, sink always ready
    t1[0] = '{d: 8'd10, sof: 1'b1, sol: 1'b1, eol: 1'b0, eof: 1'b0};
    t1[1] = '{d: 8'd10, sof: 1'b0, sol: 1'b0, eol: 1'b0, eof: 1'b0};
    t1[2] = '{d: 8'd10, sof: 1'b0, sol: 1'b0, eol: 1'b0, eof: 1'b0};
    t1[3] = '{d: 8'd20, sof: 1'b0, sol: 1'b0, eol: 1'b0, eof: 1'b0};
    t1[4] = '{d: 8'd30, sof: 1'b0, sol: 1'b0, eol: 1'b0, eof: 1'b0};
    t1[5] = '{d: 8'd40, sof: 1'b0, sol: 1'b0, eol: 1'b0, eof: 1'b0};
    t1[6] = '{d: 8'd40, sof: 1'b0, sol: 1'b0, eol: 1'b0, eof: 1'b0};
    t1[7] = '{d: 8'd40, sof: 1'b0, sol: 1'b0, eol: 1'b1, eof: 1'b1};
    h_size = LC'(3);
    v_size = LC'(0);
    for (int i = 0; i < 8; i++) exp_q.push_back(t1[i]);
    src_q.push_back(8'd10);
    src_q.push_back(8'd20);
    src_q.push_back(8'd30);
    src_q.push_back(8'd40);
    run_stream("t1", 200, 0, 1'b0, -1, 0);
    check("t1_sready_low_cycles", 32'(low_rdy), 32'd4);

    // Test 2: same line under a stalling sink and input gaps
    add_frame(3, 0, 10, 10, 1'b0);
    run_stream("t2", 400, 1, 1'b1, -1, 0);

    // Test 3: single-pixel line
    h_size = LC'(0);
    add_frame(0, 0, 55, 0, 1'b0);
    run_stream("t3", 200, 0, 1'b0, -1, 0);

    // Test 4: two-line frames back to back, sof/eof only at frame ends
    h_size = LC'(1);
    v_size = LC'(1);
    add_frame(1, 1, 1, 1, 1'b0);
    add_frame(1, 1, 5, 1, 1'b0);
    run_stream("t4", 400, 0, 1'b0, -1, 0);

    // Test 5: h_size changes during line 0, takes effect only next frame
    h_size = LC'(3);
    v_size = LC'(1);
    add_frame(3, 1, 0, 0, 1'b1);
    add_frame(5, 1, 0, 0, 1'b1);
    run_stream("t5", 600, 2, 1'b1, 2, 5);

    // Test 6: reset pulse during left padding discards the line
    h_size  = LC'(1);
    v_size  = LC'(0);
    s_valid = 1'b1;
    s_data  = 8'd77;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    check("t6_sready_in_reset", 32'(s_ready_o), 32'd0);
    @(posedge clk);
    #1;
    check("t6_m_valid", 32'(m_valid_o), 32'd0);
    check("t6_word", 32'(dut_word()), 32'd0);
    rst_n = 1'b1;
    add_frame(1, 0, 5, 1, 1'b0);
    run_stream("t6", 200, 0, 1'b0, -1, 0);

    // Randomized frames: random geometry, data, input gaps and sink stalls
    for (int t = 0; t < 12; t++) begin
      int h, v;
      h = $urandom_range(0, 6);
      v = $urandom_range(0, 2);
      h_size = LC'(h);
      v_size = LC'(v);
      add_frame(h, v, 0, 0, 1'b1);
      run_stream("rnd", 2000, 2, 1'b1, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
